// File: rtl/alu_rr_arbiter_if.sv
// alu_rr_arbiter_if: requester-side bus of the shared-ALU arbiter.
//   req_valid/req_ready : per-requester request handshake (ready is one-hot)
//   req_op/in0/in1      : flattened per-requester payload, requester i at slice i
//   rsp_valid/rsp_ready : per-requester response handshake (valid is one-hot)
//   rsp_data/rsp_err    : buffered result shared by all requesters
// master = requester side, slave = arbiter side.
interface alu_rr_arbiter_if #(
  parameter int N_BITS  = 32,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [4*NUM_REQ-1:0]      req_op;
  logic [N_BITS*NUM_REQ-1:0] req_in0;
  logic [N_BITS*NUM_REQ-1:0] req_in1;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [N_BITS-1:0]         rsp_data;
  logic                      rsp_err;

  modport master (
    output req_valid, req_op, req_in0, req_in1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_in0, req_in1, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one combinational RV32I ALU between NUM_REQ requesters.
// Round-robin grant into a one-entry registered response buffer; a buffered
// response can drain and be refilled in the same cycle (1 result/cycle).
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   bus (slave)     : requester handshake/payload and response buffer outputs
//   alu_op/in0/in1  : drive to the external ALU (zeroed when nothing is granted)
//   alu_out         : combinational ALU result, captured on the accept edge
module alu_rr_arbiter #(
  parameter int N_BITS  = 32,
  parameter int NUM_REQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_rr_arbiter_if.slave   bus,
  output logic [3:0]        alu_op,
  output logic [N_BITS-1:0] alu_in0,
  output logic [N_BITS-1:0] alu_in1,
  input  logic [N_BITS-1:0] alu_out
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_e;

  buf_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [N_BITS-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic               fire_rsp, can_accept;
  logic               gnt_vld;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W:0]     scan_idx;
  logic [3:0]         op_sel;
  logic [N_BITS-1:0]  in0_sel, in1_sel;
  logic               op_ok;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110,
      4'b1000, 4'b1010, 4'b1011, 4'b1100, 4'b1110: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  // Rotating priority scan starting at ptr_q; scan_idx is one bit wider so
  // ptr+k can be folded back below NUM_REQ without a modulo.
  always_comb begin
    fire_rsp   = |(rsp_valid_q & bus.rsp_ready);
    can_accept = (state_q == EMPTY) || fire_rsp;
    gnt_vld    = 1'b0;
    gnt_idx    = '0;
    scan_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (scan_idx >= (IDX_W+1)'(NUM_REQ))
        scan_idx = scan_idx - (IDX_W+1)'(NUM_REQ);
      if (can_accept && !gnt_vld && bus.req_valid[scan_idx[IDX_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx[IDX_W-1:0];
      end
    end
    gnt          = '0;
    gnt[gnt_idx] = gnt_vld;
  end

  always_comb begin
    op_sel  = bus.req_op[{gnt_idx, 2'b00} +: 4];
    in0_sel = bus.req_in0[32'(gnt_idx)*N_BITS +: N_BITS];
    in1_sel = bus.req_in1[32'(gnt_idx)*N_BITS +: N_BITS];
    op_ok   = op_legal(op_sel);
    // Quiet bus when idle so the ALU inputs don't toggle on stale payloads.
    alu_op  = gnt_vld ? op_sel  : 4'b0000;
    alu_in0 = gnt_vld ? in0_sel : '0;
    alu_in1 = gnt_vld ? in1_sel : '0;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (gnt_vld) begin
      state_d     = FULL;
      rsp_valid_d = gnt;
      rsp_data_d  = op_ok ? alu_out : '0;
      rsp_err_d   = !op_ok;
      ptr_d       = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end else if (fire_rsp) begin
      // Drain only: data/err keep their last value.
      state_d     = EMPTY;
      rsp_valid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule
